// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-register slice: default widths,
// the bubble instruction, CP0 exception codes and the saturating Tnew countdown.
package pipe_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 5;
    localparam int unsigned TW_DEF = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Tnew counts down by dec per stage but stops at zero instead of wrapping.
    function automatic int unsigned tnew_sat_dec(input int unsigned tnew, input int unsigned dec);
        return (tnew > dec) ? tnew - dec : 32'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of one pipeline register stage.
// Exception fields exist only when PIPE_EXC_EN is defined.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned TW = TW_DEF
);
    logic          en;
    logic          clr;
    logic          valid_i;
    logic [DW-1:0] instr_i;
    logic [DW-1:0] pc4_i;
    logic [DW-1:0] rt_i;
    logic [DW-1:0] alu_i;
    logic [AW-1:0] a3_i;
    logic [TW-1:0] tnew_i;
    logic [DW-1:0] wd_i;

    logic          valid_o;
    logic [DW-1:0] instr_o;
    logic [DW-1:0] pc4_o;
    logic [DW-1:0] rt_o;
    logic [DW-1:0] alu_o;
    logic [AW-1:0] fwd_a3_o;
    logic [TW-1:0] fwd_tnew_o;
    logic [DW-1:0] fwd_wd_o;
    logic          fwd_hit_o;
`ifdef PIPE_EXC_EN
    logic [4:0]    exc_i;
    logic [0:0]    bd_i;
    logic [4:0]    exc_o;
    logic [0:0]    bd_o;
`endif

    modport master (
        output en, clr, valid_i, instr_i, pc4_i, rt_i, alu_i, a3_i, tnew_i, wd_i,
`ifdef PIPE_EXC_EN
        output exc_i, bd_i,
        input  exc_o, bd_o,
`endif
        input  valid_o, instr_o, pc4_o, rt_o, alu_o, fwd_a3_o, fwd_tnew_o, fwd_wd_o, fwd_hit_o
    );

    modport slave (
        input  en, clr, valid_i, instr_i, pc4_i, rt_i, alu_i, a3_i, tnew_i, wd_i,
`ifdef PIPE_EXC_EN
        input  exc_i, bd_i,
        output exc_o, bd_o,
`endif
        output valid_o, instr_o, pc4_o, rt_o, alu_o, fwd_a3_o, fwd_tnew_o, fwd_wd_o, fwd_hit_o
    );

endinterface

// File: rtl/pipe_field_reg.sv
// One field of a pipeline register: reset/flush load RSTV, stall holds, else load d.
module pipe_field_reg #(
    parameter int unsigned  W    = 1,
    parameter logic [W-1:0] RSTV = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= RSTV;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, valid bit and forwarding outputs.
// Optional exception/branch-delay fields are built when PIPE_EXC_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned   DW        = DW_DEF,
    parameter int unsigned   AW        = AW_DEF,
    parameter int unsigned   TW        = TW_DEF,
    parameter int unsigned   TNEW_DEC  = 1,
    parameter logic [DW-1:0] BUBBLE_IR = DW'(NOP_INSTR)
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);

    logic          valid_q;
    logic          fwd_ok;
    logic [AW-1:0] a3_d;
    logic [AW-1:0] a3_q;
    logic [TW-1:0] tnew_d;
    logic [TW-1:0] tnew_q;

    // A bubble (or a faulting instruction) loads a3=0 so it can never forward.
    always_comb begin
        fwd_ok = bus.valid_i;
`ifdef PIPE_EXC_EN
        fwd_ok = bus.valid_i && (bus.exc_i == '0);
`endif
        a3_d   = fwd_ok ? bus.a3_i : '0;
        tnew_d = TW'(tnew_sat_dec(32'(bus.tnew_i), TNEW_DEC));
    end

    pipe_field_reg #(.W(1)) u_valid (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.valid_i), .q(valid_q));
    pipe_field_reg #(.W(DW), .RSTV(BUBBLE_IR)) u_instr (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.instr_i), .q(bus.instr_o));
    pipe_field_reg #(.W(DW)) u_pc4 (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.pc4_i), .q(bus.pc4_o));
    pipe_field_reg #(.W(DW)) u_rt (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.rt_i), .q(bus.rt_o));
    pipe_field_reg #(.W(DW)) u_alu (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.alu_i), .q(bus.alu_o));
    pipe_field_reg #(.W(DW)) u_wd (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.wd_i), .q(bus.fwd_wd_o));
    pipe_field_reg #(.W(AW)) u_a3 (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(a3_d), .q(a3_q));
    pipe_field_reg #(.W(TW)) u_tnew (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(tnew_d), .q(tnew_q));
`ifdef PIPE_EXC_EN
    pipe_field_reg #(.W(5)) u_exc (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.exc_i), .q(bus.exc_o));
    pipe_field_reg #(.W(1)) u_bd (
        .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en), .d(bus.bd_i), .q(bus.bd_o));
`endif

    always_comb begin
        bus.valid_o    = valid_q;
        bus.fwd_a3_o   = valid_q ? a3_q : '0;
        bus.fwd_tnew_o = tnew_q;
        bus.fwd_hit_o  = valid_q && (a3_q != '0) && (tnew_q == '0);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (default parameters, TNEW_DEC=1).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DW(32), .AW(5), .TW(2)) bus ();

    pipe_stage_reg #(
        .DW(32), .AW(5), .TW(2), .TNEW_DEC(1), .BUBBLE_IR(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [31:0] instr, pc4, rt, alu, wd;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic        hit;
        logic [4:0]  exc;
        logic        bd;
        logic        full;
    } exp_t;

    typedef struct {
        logic        rst, en, clr, v;
        logic [31:0] instr, wd;
        logic [4:0]  a3;
        logic [1:0]  tnew;
        logic        evalid;
        logic [31:0] einstr, ewd;
        logic [4:0]  ea3;
        logic [1:0]  etnew;
        logic        ehit;
    } vec_t;

    vec_t tbl[15];
    exp_t q[$];
    exp_t m;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic en, input logic clr, input logic v,
                         input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] rt,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] a3,
                         input logic [1:0] tnew, input logic [4:0] exc, input logic bd);
        reset       = rst;
        bus.en      = en;
        bus.clr     = clr;
        bus.valid_i = v;
        bus.instr_i = instr;
        bus.pc4_i   = pc4;
        bus.rt_i    = rt;
        bus.alu_i   = alu;
        bus.wd_i    = wd;
        bus.a3_i    = a3;
        bus.tnew_i  = tnew;
`ifdef PIPE_EXC_EN
        bus.exc_i   = exc;
        bus.bd_i    = bd;
`else
        if (exc != 5'd0 || bd) begin end
`endif
    endtask

    task automatic check_out();
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue: got empty expected one entry");
            return;
        end
        e = q.pop_front();
        chk("valid_o",    32'(bus.valid_o),    32'(e.valid));
        chk("instr_o",    bus.instr_o,         e.instr);
        chk("fwd_wd_o",   bus.fwd_wd_o,        e.wd);
        chk("fwd_a3_o",   32'(bus.fwd_a3_o),   32'(e.a3));
        chk("fwd_tnew_o", 32'(bus.fwd_tnew_o), 32'(e.tnew));
        chk("fwd_hit_o",  32'(bus.fwd_hit_o),  32'(e.hit));
        if (e.full) begin
            chk("pc4_o", bus.pc4_o, e.pc4);
            chk("rt_o",  bus.rt_o,  e.rt);
            chk("alu_o", bus.alu_o, e.alu);
        end
`ifdef PIPE_EXC_EN
        chk("exc_o", 32'(bus.exc_o), 32'(e.exc));
        chk("bd_o",  32'(bus.bd_o),  32'(e.bd));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Reference behaviour of one clock edge, applied to the bench's own state copy.
    task automatic model_step(input logic rst, input logic en, input logic clr, input logic v,
                              input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] rt,
                              input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] a3,
                              input logic [1:0] tnew, input logic [4:0] exc, input logic bd);
        logic ok;
        ok = v;
`ifdef PIPE_EXC_EN
        ok = v && (exc == 5'd0);
`endif
        if (rst || clr) begin
            m = '{default: '0};
        end else if (en) begin
            m.valid = v;
            m.instr = instr;
            m.pc4   = pc4;
            m.rt    = rt;
            m.alu   = alu;
            m.wd    = wd;
            m.a3    = ok ? a3 : 5'd0;
            m.tnew  = (tnew > 2'd1) ? tnew - 2'd1 : 2'd0;
            m.exc   = exc;
            m.bd    = bd;
        end
        m.hit  = m.valid && (m.a3 != 5'd0) && (m.tnew == 2'd0);
        m.full = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic rst, en, clr, v, bd;
        logic [31:0] ins, pc4, rt, alu, wd;
        logic [4:0] a3, exc;
        logic [1:0] tn;

        //        rst en clr v  instr          wd       a3 tn  ev einstr         ewd      ea3 et eh
        tbl[0]  = '{1, 1, 0, 0, 32'h0,         32'h0,    0, 0, 0, 32'h0,         32'h0,    0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 32'hAAAA0001,  32'h1234, 8, 2, 1, 32'hAAAA0001,  32'h1234, 8, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 32'hFFFFFFFF,  32'h9999, 3, 0, 1, 32'hAAAA0001,  32'h1234, 8, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 32'hFFFFFFFF,  32'h9999, 3, 0, 1, 32'hAAAA0001,  32'h1234, 8, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 32'h1,         32'h2,    5, 3, 1, 32'hAAAA0001,  32'h1234, 8, 1, 0};
        tbl[5]  = '{0, 1, 0, 1, 32'h22,        32'h55,   8, 0, 1, 32'h22,        32'h55,   8, 0, 1};
        tbl[6]  = '{0, 1, 0, 1, 32'h33,        32'h66,  10, 1, 1, 32'h33,        32'h66,  10, 0, 1};
        tbl[7]  = '{0, 0, 1, 1, 32'h44,        32'h77,  11, 2, 0, 32'h0,         32'h0,    0, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 32'h88,        32'h5,    0, 0, 1, 32'h88,        32'h5,    0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 32'h99,        32'hAB,   7, 3, 0, 32'h99,        32'hAB,   0, 2, 0};
        tbl[10] = '{0, 1, 0, 1, 32'hA0,        32'hCD,   7, 3, 1, 32'hA0,        32'hCD,   7, 2, 0};
        tbl[11] = '{1, 0, 0, 1, 32'hB0,        32'hEF,   6, 1, 0, 32'h0,         32'h0,    0, 0, 0};
        tbl[12] = '{0, 1, 0, 1, 32'hC0,        32'h11,  31, 2, 1, 32'hC0,        32'h11,  31, 1, 0};
        tbl[13] = '{0, 1, 1, 1, 32'hD0,        32'h22,   4, 0, 0, 32'h0,         32'h0,    0, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 32'hE0,        32'h33,   4, 0, 0, 32'h0,         32'h0,    0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].v, tbl[i].instr,
                  tbl[i].instr + 32'd4, ~tbl[i].instr, tbl[i].wd ^ 32'h5A5A,
                  tbl[i].wd, tbl[i].a3, tbl[i].tnew, 5'd0, 1'b0);
            e = '{default: '0};
            e.valid = tbl[i].evalid;
            e.instr = tbl[i].einstr;
            e.wd    = tbl[i].ewd;
            e.a3    = tbl[i].ea3;
            e.tnew  = tbl[i].etnew;
            e.hit   = tbl[i].ehit;
            q.push_back(e);
            cycle();
        end

        // Exception-suppressed forwarding: exc=Ov with a3=9 must not forward when the feature is built.
        apply(0, 1, 0, 1, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h77, 9, 0, EXC_OV, 1);
        e = '{default: '0};
        e.valid = 1'b1; e.instr = 32'h1000; e.pc4 = 32'h2000; e.rt = 32'h3000;
        e.alu = 32'h4000; e.wd = 32'h77; e.tnew = 2'd0; e.full = 1'b1;
`ifdef PIPE_EXC_EN
        e.a3 = 5'd0; e.hit = 1'b0; e.exc = 5'd12; e.bd = 1'b1;
`else
        e.a3 = 5'd9; e.hit = 1'b1;
`endif
        q.push_back(e);
        cycle();

        // Flush then reset while stalled; both clear the held exception state.
        apply(0, 0, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 6, 1, EXC_RI, 1);
        q.push_back('{default: '0});
        cycle();

        m = '{default: '0};
        apply(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
        model_step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0, 0);
        q.push_back(m);
        cycle();

        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 4) != 0);
            ins = $urandom; pc4 = $urandom; rt = $urandom; alu = $urandom; wd = $urandom;
            a3  = 5'($urandom_range(0, 31));
            tn  = 2'($urandom_range(0, 3));
            exc = ($urandom_range(0, 3) == 0) ? EXC_ADEL : EXC_INT;
            bd  = 1'($urandom_range(0, 1));
            apply(rst, en, clr, v, ins, pc4, rt, alu, wd, a3, tn, exc, bd);
            model_step(rst, en, clr, v, ins, pc4, rt, alu, wd, a3, tn, exc, bd);
            q.push_back(m);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
